// File: rtl/l1d_pkg.sv
// l1d_pkg: shared L1D line geometry and store-size encoding
package l1d_pkg;
  localparam int L1D_LINE_BYTES = 16;
  localparam int L1D_LINE_BITS  = 128;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} st_size_e;
endpackage

// File: rtl/l1d_st_align.sv
// l1d_st_align: place an LSB-aligned store into its line byte lanes with a byte mask
module l1d_st_align
  import l1d_pkg::*;
(
  input  logic [3:0]                offset,
  input  st_size_e                  size,
  input  logic [63:0]               data,
  output logic [L1D_LINE_BYTES-1:0] mask,
  output logic [L1D_LINE_BITS-1:0]  line
);
  always_comb begin
    mask = ((16'd1 << (5'd1 << size)) - 16'd1) << offset;
    line = {{(L1D_LINE_BITS-64){1'b0}}, data} << {offset, 3'b000};
  end
endmodule

// File: rtl/l1d_store_buffer.sv
// l1d_store_buffer: merging FIFO store buffer with load forwarding in front of the L1D data RAM
module l1d_store_buffer
  import l1d_pkg::*;
#(
  parameter int LG_DEPTH   = 8,
  parameter int LG_ENTRIES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      st_valid,
  output logic                      st_ready,
  input  logic [LG_DEPTH-1:0]       st_addr,
  input  logic [3:0]                st_offset,
  input  logic [1:0]                st_size,
  input  logic [63:0]               st_data,
  input  logic                      wr_stall,
  output logic                      wr_en,
  output logic [LG_DEPTH-1:0]       wr_addr,
  output logic [L1D_LINE_BITS-1:0]  wr_data,
  output logic [L1D_LINE_BYTES-1:0] wr_byte_en,
  input  logic [LG_DEPTH-1:0]       ld_addr,
  output logic                      ld_hit,
  output logic [L1D_LINE_BITS-1:0]  ld_data,
  output logic [L1D_LINE_BYTES-1:0] ld_byte_en,
  output logic                      empty
);
  localparam int NE = 1 << LG_ENTRIES;
  logic [LG_DEPTH-1:0]       idx_q [NE];
  logic [LG_DEPTH-1:0]       idx_d [NE];
  logic [L1D_LINE_BITS-1:0]  data_q [NE];
  logic [L1D_LINE_BITS-1:0]  data_d [NE];
  logic [L1D_LINE_BYTES-1:0] mask_q [NE];
  logic [L1D_LINE_BYTES-1:0] mask_d [NE];
  logic [LG_ENTRIES-1:0]     head_q, head_d, tail_q, tail_d, tl, wi;
  logic [LG_ENTRIES:0]       count_q, count_d;
  logic                      wr_en_q, wr_en_d;
  logic [LG_DEPTH-1:0]       wr_addr_q, wr_addr_d;
  logic [L1D_LINE_BITS-1:0]  wr_data_q, wr_data_d, base;
  logic [L1D_LINE_BYTES-1:0] wr_byte_en_q, wr_byte_en_d;
  logic [L1D_LINE_BYTES-1:0] al_mask;
  logic [L1D_LINE_BITS-1:0]  al_line;
  logic                      drain_fire, merge_ok, accept, push;
  l1d_st_align u_align (
    .offset(st_offset),
    .size  (st_size_e'(st_size)),
    .data  (st_data),
    .mask  (al_mask),
    .line  (al_line)
  );
  always_comb begin
    tl         = tail_q - LG_ENTRIES'(1);
    drain_fire = count_q != '0 && !wr_stall;
    merge_ok   = count_q != '0 && idx_q[tl] == st_addr && !(count_q == (LG_ENTRIES+1)'(1) && drain_fire);
    st_ready   = reset && (merge_ok || count_q < (LG_ENTRIES+1)'(NE));
    accept     = st_valid && st_ready;
    push       = accept && !merge_ok;
    wi         = merge_ok ? tl : tail_q;
    base       = merge_ok ? data_q[wi] : '0;
    idx_d      = idx_q;
    data_d     = data_q;
    mask_d     = mask_q;
    if (accept) begin
      idx_d[wi]  = st_addr;
      mask_d[wi] = (merge_ok ? mask_q[wi] : '0) | al_mask;
      for (int b = 0; b < L1D_LINE_BYTES; b++)
        data_d[wi][8*b +: 8] = al_mask[b] ? al_line[8*b +: 8] : base[8*b +: 8];
    end
    head_d       = head_q + LG_ENTRIES'(drain_fire);
    tail_d       = tail_q + LG_ENTRIES'(push);
    count_d      = count_q + (LG_ENTRIES+1)'(push) - (LG_ENTRIES+1)'(drain_fire);
    wr_en_d      = drain_fire;
    wr_addr_d    = drain_fire ? idx_q[head_q] : wr_addr_q;
    wr_data_d    = drain_fire ? data_q[head_q] : wr_data_q;
    wr_byte_en_d = drain_fire ? mask_q[head_q] : wr_byte_en_q;
  end
  always_ff @(posedge clk) begin
    idx_q  <= idx_d;
    data_q <= data_d;
    mask_q <= mask_d;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_byte_en_q <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_byte_en_q <= wr_byte_en_d;
    end
  end
  always_comb begin
    ld_byte_en = '0;
    ld_data    = '0;
    for (int b = 0; b < L1D_LINE_BYTES; b++)
      if (wr_en_q && wr_addr_q == ld_addr && wr_byte_en_q[b]) begin
        ld_byte_en[b]     = 1'b1;
        ld_data[8*b +: 8] = wr_data_q[8*b +: 8];
      end
    for (int i = 0; i < NE; i++)
      if ((LG_ENTRIES+1)'(i) < count_q && idx_q[head_q + LG_ENTRIES'(i)] == ld_addr)
        for (int b = 0; b < L1D_LINE_BYTES; b++)
          if (mask_q[head_q + LG_ENTRIES'(i)][b]) begin
            ld_byte_en[b]     = 1'b1;
            ld_data[8*b +: 8] = data_q[head_q + LG_ENTRIES'(i)][8*b +: 8];
          end
    ld_hit = |ld_byte_en;
  end
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_byte_en = wr_byte_en_q;
  assign empty      = !reset || (count_q == '0 && !wr_en_q);
  assert property (@(posedge clk) disable iff (!reset)
    (st_valid && st_ready) |-> (st_offset & 4'((1 << st_size) - 1)) == 4'd0);
endmodule

// File: doc/l1d_store_buffer.md
L1D_STORE_BUFFER -- requirements
Module: l1d_store_buffer

Interface
REQ-001 SHALL have parameter LG_DEPTH, default 8: line-index width; matches the downstream L1D data RAM.
REQ-002 SHALL have parameter LG_ENTRIES, default 2: log2 of buffer entries (4 entries).
REQ-003 SHALL have clk  in  1: single clock; all state updates on the posedge.
REQ-004 SHALL have reset  in  1: synchronous, active-low reset.
REQ-005 SHALL have st_valid  in  1 and st_ready  out  1: store request handshake.
REQ-006 SHALL have st_addr  in  LG_DEPTH: line index; st_offset  in  4: byte offset in the 16-byte line.
REQ-007 SHALL have st_size  in  2: 0=1B, 1=2B, 2=4B, 3=8B; st_data  in  64: store data, LSB-aligned.
REQ-008 SHALL have wr_stall  in  1: RAM write port busy (refill); no drain while high.
REQ-009 SHALL have wr_en  out  1, wr_addr  out  LG_DEPTH, wr_data  out  128, wr_byte_en  out  16: registered drain port to the L1D data RAM.
REQ-010 SHALL have ld_addr  in  LG_DEPTH, ld_hit  out  1, ld_data  out  128, ld_byte_en  out  16: combinational load-forwarding lookup.
REQ-011 SHALL have empty  out  1: high when no entry is valid and wr_en is low.

Function
REQ-012 SHALL form the store mask as ((1<<(1<<st_size))-1)<<st_offset, and the store data as st_data zero-extended to 128 bits and shifted left by st_offset*8.
REQ-013 SHALL require natural alignment (st_offset a multiple of the size in bytes); a simulation assertion SHALL fire on a misaligned store, with the buffered result undefined.
REQ-014 SHALL hold entries in FIFO order, each entry being {index, 128-bit data, 16-bit mask}; count ranges 0..2^LG_ENTRIES.
REQ-015 SHALL define drain_fire = (count!=0) & !wr_stall; on drain_fire the head entry is popped and, at the same edge, wr_en<=1 and wr_addr/wr_data/wr_byte_en<=head contents; otherwise wr_en<=0.
REQ-016 SHALL define merge_ok = (count!=0) & (tail.index==st_addr) & !(count==1 & drain_fire); a store accepted with merge_ok sets tail.mask|=mask and overwrites only the masked bytes of tail.data.
REQ-017 SHALL set st_ready = merge_ok | (count < 2^LG_ENTRIES); when full, ready SHALL NOT rely on a same-cycle pop.
REQ-018 SHALL allocate a new tail entry for an accepted store when merge_ok is low; a simultaneous push and pop SHALL leave count unchanged.
REQ-019 SHALL compute ld_byte_en as the OR of masks over the valid entries and the in-flight wr_* register (when wr_en is high) whose index equals ld_addr; ld_hit = |ld_byte_en.
REQ-020 SHALL build ld_data byte by byte with youngest-wins priority (tail > ... > head > in-flight wr_*); bytes not covered SHALL be 0.
REQ-021 SHALL exclude from forwarding any store being accepted in the same cycle; it becomes visible from the next cycle.
REQ-022 SHALL wrap head and tail pointers modulo 2^LG_ENTRIES.

Reset
REQ-023 SHALL, while reset is low at a posedge, set count=0, head=tail=0, wr_en=0, wr_addr=0, wr_data=0, wr_byte_en=0; entry payloads need not be cleared.
REQ-024 SHALL, during reset, drive st_ready=0 and empty=1, and discard stores and in-flight drains; the first acceptance SHALL occur in the first cycle after reset deasserts.

Structure
REQ-025 SHALL place the following in shared package l1d_pkg: L1D_LINE_BYTES=16, L1D_LINE_BITS=128, and the st_size encoding enum.
REQ-026 SHALL implement the mask/data alignment of REQ-012 in sub-module l1d_st_align, which is combinational and instantiated once.
REQ-027 SHALL keep the RTL between 120 and 400 lines, with no RAM macros; entries are flops.

Verification
REQ-028 Single store: st_addr=5, offset=4, size=2, data=0xDEADBEEF, wr_stall=0 -> next cycle wr_en=1, wr_addr=5, wr_byte_en=0x00F0, wr_data[63:32]=0xDEADBEEF; empty=1 one cycle later.
REQ-029 Merge: wr_stall=1; stores to index 3 at offset 0 (1B, 0xAA) then offset 8 (8B, 0x1122334455667788) -> count=1, mask=0xFF01; after wr_stall is released, a single write with that mask.
REQ-030 Full: wr_stall=1; 4 stores to distinct indices -> st_ready=0 for a fifth store to new index 9, but st_ready=1 for a store to the tail's index.
REQ-031 Forwarding: two stores to index 7 with an intervening store to index 8, overlapping byte 0 (0x11 then 0x22) -> ld_addr=7 gives ld_hit=1, ld_data[7:0]=0x22; byte 0 is still forwarded on the in-flight wr_en cycle.
REQ-032 Reset mid-operation: 3 entries queued, wr_stall=1, reset low for 1 cycle -> wr_en=0, empty=1, st_ready=0 during reset; no write is issued after reset is released.
